lsu: RTL
========

Name: lsu

Overview:
- Load/store unit directly downstream of the RV32I ALU; consumes its 32-bit result as the effective address (rs1+imm) for LOAD/STORE instructions.
- Drives a single-outstanding request/acknowledge data-memory port.
- Formats store lanes and strobes, and sign/zero-extends load data.
- Returns one completion pulse with data or an error code to writeback.

Parameters:
- TIMEOUT, 16, cycles to wait for mem_ack before declaring a bus error; 0 disables the timeout.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_X  input  1  asynchronous active-low reset.
- start  input  1  execute stage presents a memory op this cycle.
- instr_type  input  5  opcode[6:2]; LOAD=5'b00000, STORE=5'b01000.
- funct3  input  3  access size/sign.
- addr  input  32  effective address (ALU result).
- wdata  input  32  store data (rs2 value).
- busy  output  1  operation in flight; upstream must hold.
- done  output  1  one-cycle completion pulse.
- rdata  output  32  formatted load result; valid with done on loads, else 0.
- err  output  2  valid with done: 0 ok, 1 misaligned, 2 bus timeout, 3 illegal funct3.
- mem_req  output  1  request; held until mem_ack.
- mem_we  output  1  1=store.
- mem_addr  output  32  {addr[31:2],2'b00}.
- mem_wstrb  output  4  byte enables, stores only, else 0.
- mem_wdata  output  32  lane-replicated store data.
- mem_ack  input  1  memory accepts/completes; sampled only while mem_req=1.
- mem_rdata  input  32  read word, valid with mem_ack.

Behaviour:
- Reset (async, RST_X=0): state IDLE; every output 0, including mem_req (drops immediately, mid-transaction too); timeout counter 0; latched op discarded.
- All outputs are registered.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - start=1 with instr_type LOAD or STORE: latch funct3, addr[1:0], wdata and direction.
  - Legal and aligned: go to WAIT, assert mem_req/mem_we/mem_addr/mem_wstrb/mem_wdata from next cycle, busy=1.
  - Illegal funct3 or misaligned: go to RESP with err set, no mem_req ever raised.
  - start with any other instr_type: ignored, no response.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all others illegal.
  - Stores: 000 SB, 001 SH, 010 SW; all others illegal.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0. Illegal funct3 takes priority over misalignment.
- WAIT:
  - mem_req held with stable payload.
  - On mem_ack=1: capture and format data, drop mem_req, go to RESP.
  - Counter increments each WAIT cycle without ack. When it reaches TIMEOUT: drop mem_req, err=2, go to RESP. An ack in that same cycle wins (err=0).
- RESP (exactly one cycle): done=1, busy=0, rdata/err valid; return to IDLE. start in RESP is ignored; upstream re-presents after done.
- start while busy is ignored; no new latch.
- Latency:
  - start sampled at edge k → mem_req high after k.
  - ack sampled at edge m → done high for the cycle after m.
  - Zero-wait memory (ack in first request cycle) → done two cycles after the start edge.
  - Error paths without memory access → done one cycle after the start edge.
- Store formatting:
  - SB: mem_wdata = {4{wdata[7:0]}}, wstrb = 4'b0001 << addr[1:0].
  - SH: {2{wdata[15:0]}}, 4'b0011 << addr[1:0].
  - SW: wdata, 4'b1111.
- Load formatting: select byte/halfword lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- rdata is 0 on stores and on any err≠0.
- Timeout counter width: $clog2(TIMEOUT+1); cleared on entering WAIT.

Decomposition:
- Shared header instr_type.hv: LOAD/STORE opcode constants.
- Shared header lsu.hv:
  - FUNCT3_LB/LH/LW/LBU/LHU/SB/SH/SW.
  - ERR_NONE/ERR_MISALIGN/ERR_TIMEOUT/ERR_ILLEGAL.
  - State encodings.
- One combinational sub-module, lsu_format: store lane/strobe generation and load extract/extend, kept separate so it can be unit-tested exhaustively.

Test Plan:
- LB at addr 0x103, mem_rdata 0x80FF_1234, ack after 2 wait cycles → mem_addr=0x100, done once with rdata=0xFFFF_FF80, err=0.
- SH at addr 0x202, wdata 0xDEAD_BEEF, zero-wait ack → mem_we=1, mem_wstrb=4'b1100, mem_wdata=0xBEEF_BEEF, done two cycles after start, rdata=0.
- LW at addr 0x1001 → no mem_req; done next cycle, err=1.
- LW, mem_ack never asserted, TIMEOUT=16 → mem_req high 16 cycles then low, done with err=2, rdata=0.
- LH with funct3=3'b110 → done next cycle, err=3 (illegal beats misaligned when addr odd).
- Reset pulse during WAIT → mem_req/busy fall asynchronously; a late mem_ack after release is ignored; a new LBU at 0x7, rdata 0x8000_0000 → rdata=0x0000_0080.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsu_pkg
// Brief   : Opcode, funct3, error-code and FSM-state constants for the LSU,
//           plus the funct3 legality and alignment rules.
// Revision: 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [4:0] c_OP_LOAD  = 5'b00000;
    localparam logic [4:0] c_OP_STORE = 5'b01000;

    localparam logic [2:0] c_FUNCT3_LB  = 3'b000;
    localparam logic [2:0] c_FUNCT3_LH  = 3'b001;
    localparam logic [2:0] c_FUNCT3_LW  = 3'b010;
    localparam logic [2:0] c_FUNCT3_LBU = 3'b100;
    localparam logic [2:0] c_FUNCT3_LHU = 3'b101;
    localparam logic [2:0] c_FUNCT3_SB  = 3'b000;
    localparam logic [2:0] c_FUNCT3_SH  = 3'b001;
    localparam logic [2:0] c_FUNCT3_SW  = 3'b010;

    localparam logic [1:0] c_ERR_NONE     = 2'd0;
    localparam logic [1:0] c_ERR_MISALIGN = 2'd1;
    localparam logic [1:0] c_ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] c_ERR_ILLEGAL  = 2'd3;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    function automatic logic f_funct3_legal(input logic is_store, input logic [2:0] funct3);
        logic ok;
        ok = 1'b0;
        if (is_store) begin
            ok = (funct3 == c_FUNCT3_SB) || (funct3 == c_FUNCT3_SH) || (funct3 == c_FUNCT3_SW);
        end else begin
            ok = (funct3 == c_FUNCT3_LB)  || (funct3 == c_FUNCT3_LH) || (funct3 == c_FUNCT3_LW) ||
                 (funct3 == c_FUNCT3_LBU) || (funct3 == c_FUNCT3_LHU);
        end
        return ok;
    endfunction

    // funct3[1:0] encodes the access size for every legal load and store
    function automatic logic f_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b1;
        case (funct3[1:0])
            2'b01:   ok = ~addr_lo[0];
            2'b10:   ok = (addr_lo == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_format.sv
`default_nettype none
// ============================================================================
// Module  : lsu_format
// Brief   : Combinational store lane/strobe generation and load lane
//           extraction with sign/zero extension.
// Revision: 1.0 - initial release
// ============================================================================
module lsu_format
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte  = 8'(i_rdata >> {i_addr_lo, 3'b000});
        w_half  = 16'(i_rdata >> {i_addr_lo, 3'b000});
        o_wstrb = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;

        case (i_funct3[1:0])
            2'b00: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_wstrb = 4'b0011 << i_addr_lo;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_wstrb = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase

        case (i_funct3)
            c_FUNCT3_LB:  o_rdata = {{24{w_byte[7]}}, w_byte};
            c_FUNCT3_LH:  o_rdata = {{16{w_half[15]}}, w_half};
            c_FUNCT3_LBU: o_rdata = {24'd0, w_byte};
            c_FUNCT3_LHU: o_rdata = {16'd0, w_half};
            default:      o_rdata = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module  : lsu
// Brief   : RV32I load/store unit with a single-outstanding req/ack data port.
// Revision: 1.0 - initial release
// ============================================================================
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic        start,
    input  logic [4:0]  instr_type,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic [1:0]  err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int                 c_CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [1:0]         r_state;
    logic [2:0]         r_funct3;
    logic [1:0]         r_addr_lo;
    logic               r_is_store;
    logic [c_CNT_W-1:0] r_cnt;

    logic               r_busy;
    logic               r_done;
    logic [31:0]        r_rdata;
    logic [1:0]         r_err;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [31:0]        r_mem_addr;
    logic [3:0]         r_mem_wstrb;
    logic [31:0]        r_mem_wdata;

    logic               w_is_mem;
    logic               w_is_store;
    logic               w_legal;
    logic               w_aligned;
    logic [2:0]         w_fmt_funct3;
    logic [1:0]         w_fmt_addr_lo;
    logic [3:0]         w_fmt_wstrb;
    logic [31:0]        w_fmt_wdata;
    logic [31:0]        w_fmt_rdata;

    // The formatter sees the live request in IDLE (store lanes) and the
    // latched op afterwards (load extraction on ack).
    assign w_is_store    = (instr_type == c_OP_STORE);
    assign w_is_mem      = start && ((instr_type == c_OP_LOAD) || w_is_store);
    assign w_legal       = f_funct3_legal(w_is_store, funct3);
    assign w_aligned     = f_aligned(funct3, addr[1:0]);
    assign w_fmt_funct3  = (r_state == c_ST_IDLE) ? funct3 : r_funct3;
    assign w_fmt_addr_lo = (r_state == c_ST_IDLE) ? addr[1:0] : r_addr_lo;

    lsu_format u_format (
        .i_funct3  (w_fmt_funct3),
        .i_addr_lo (w_fmt_addr_lo),
        .i_wdata   (wdata),
        .i_rdata   (mem_rdata),
        .o_wstrb   (w_fmt_wstrb),
        .o_wdata   (w_fmt_wdata),
        .o_rdata   (w_fmt_rdata)
    );

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_state     <= c_ST_IDLE;
            r_funct3    <= 3'd0;
            r_addr_lo   <= 2'd0;
            r_is_store  <= 1'b0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rdata     <= 32'd0;
            r_err       <= c_ERR_NONE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wstrb <= 4'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_is_mem) begin
                        r_funct3   <= funct3;
                        r_addr_lo  <= addr[1:0];
                        r_is_store <= w_is_store;
                        if (!w_legal) begin
                            r_state <= c_ST_RESP;
                            r_done  <= 1'b1;
                            r_err   <= c_ERR_ILLEGAL;
                            r_rdata <= 32'd0;
                        end else if (!w_aligned) begin
                            r_state <= c_ST_RESP;
                            r_done  <= 1'b1;
                            r_err   <= c_ERR_MISALIGN;
                            r_rdata <= 32'd0;
                        end else begin
                            r_state     <= c_ST_WAIT;
                            r_busy      <= 1'b1;
                            r_cnt       <= '0;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= w_is_store;
                            r_mem_addr  <= {addr[31:2], 2'b00};
                            r_mem_wstrb <= w_is_store ? w_fmt_wstrb : 4'd0;
                            r_mem_wdata <= w_is_store ? w_fmt_wdata : 32'd0;
                        end
                    end
                end

                c_ST_WAIT: begin
                    // An ack in the final counted cycle still completes normally
                    if (mem_ack || ((TIMEOUT != 0) && (r_cnt == c_CNT_LAST))) begin
                        r_state     <= c_ST_RESP;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= 32'd0;
                        r_mem_wstrb <= 4'd0;
                        r_mem_wdata <= 32'd0;
                        r_err       <= mem_ack ? c_ERR_NONE : c_ERR_TIMEOUT;
                        r_rdata     <= (mem_ack && !r_is_store) ? w_fmt_rdata : 32'd0;
                    end else if (TIMEOUT != 0) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                    r_done  <= 1'b0;
                    r_err   <= c_ERR_NONE;
                    r_rdata <= 32'd0;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign rdata     = r_rdata;
    assign err       = r_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wstrb = r_mem_wstrb;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire
